// File: rtl/ram_serial_port_if.sv
// Serial bus link between the bus master and the RAM access port.
// The master drives framed bits in; the port answers with read data and status.
interface ram_serial_port_if;
  logic bus_in;
  logic bus_in_valid;
  logic bus_out;
  logic bus_out_valid;
  logic busy;
  logic done;
  logic err;

  modport master (
    output bus_in, bus_in_valid,
    input  bus_out, bus_out_valid, busy, done, err
  );

  modport slave (
    input  bus_in, bus_in_valid,
    output bus_out, bus_out_valid, busy, done, err
  );
endinterface

// File: rtl/ram_serial_port.sv
// Bus-side access port for a 12-bit-address / 8-bit-data RAM.
// Receives bit-serial frames {rw, addr MSB-first, [data MSB-first]}. It performs
// a single-cycle RAM write, or a one-cycle RAM read whose data is then shifted
// back MSB-first. A frame that stalls for TIMEOUT idle cycles is dropped.
module ram_serial_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clock,
  input  logic                  rstn,
  ram_serial_port_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, RX_DATA, WRITE, READ, TX, DONE, ABORT
  } state_t;

  state_t                state;
  logic                  rw;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         idle_cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  // Shared between write data reception and read data transmission; the
  // RAM only looks at ram_data_in while ram_wren is high.
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  bus_out_r;
  logic                  bus_out_valid_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;

  assign ram_address       = addr_sr;
  assign ram_data_in       = data_sr;
  assign bus.bus_out       = bus_out_r;
  assign bus.bus_out_valid = bus_out_valid_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.err           = err_r;

  // Frame FSM; every output is registered and set on the transition that enters its state.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      rw              <= 1'b0;
      bit_cnt         <= '0;
      idle_cnt        <= '0;
      addr_sr         <= '0;
      data_sr         <= '0;
      bus_out_r       <= 1'b0;
      bus_out_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      err_r           <= 1'b0;
      ram_wren        <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      ram_wren <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bus_in_valid) begin
            rw       <= bus.bus_in;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            busy_r   <= 1'b1;
            state    <= RX_ADDR;
          end
        end
        RX_ADDR: begin
          if (bus.bus_in_valid) begin
            addr_sr  <= {addr_sr[ADDR_WIDTH-2:0], bus.bus_in};
            idle_cnt <= '0;
            if (bit_cnt == CW'(ADDR_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= rw ? RX_DATA : READ;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            err_r <= 1'b1;
            state <= ABORT;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        RX_DATA: begin
          if (bus.bus_in_valid) begin
            data_sr  <= {data_sr[DATA_WIDTH-2:0], bus.bus_in};
            idle_cnt <= '0;
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              bit_cnt  <= '0;
              ram_wren <= 1'b1;
              state    <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
            err_r <= 1'b1;
            state <= ABORT;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        WRITE: begin
          done_r <= 1'b1;
          state  <= DONE;
        end
        READ: begin
          // Address has been stable for a full cycle; capture the combinational read.
          data_sr         <= ram_data_out;
          bus_out_r       <= ram_data_out[DATA_WIDTH-1];
          bus_out_valid_r <= 1'b1;
          bit_cnt         <= '0;
          state           <= TX;
        end
        TX: begin
          if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
            bus_out_r       <= 1'b0;
            bus_out_valid_r <= 1'b0;
            done_r          <= 1'b1;
            state           <= DONE;
          end else begin
            data_sr   <= {data_sr[DATA_WIDTH-2:0], 1'b0};
            bus_out_r <= data_sr[DATA_WIDTH-2];
            bit_cnt   <= bit_cnt + CW'(1);
          end
        end
        DONE, ABORT: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_serial_port.sv
// Scoreboarded bench for ram_serial_port: the stimulus pushes expected
// {kind, cycle, addr, value} events, and a negedge monitor pops them as the DUT responds.
module tb_ram_serial_port;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int K_WREN = 0, K_BIT = 1, K_DONE = 2, K_ERR = 3;

  logic          clock = 1'b0;
  logic          rstn  = 1'b1;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_wren;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    int            cyc;
  } ev_t;
  ev_t sb[$];

  ram_serial_port_if bif();

  ram_serial_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clock        (clock),
    .rstn         (rstn),
    .bus          (bif),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_wren     (ram_wren),
    .ram_data_out (ram_data_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // RAM model: clocked write, combinational read
  always @(posedge clock) if (ram_wren) mem[ram_address] <= ram_data_in;
  assign ram_data_out = mem[ram_address];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.val = v; e.cyc = c;
    sb.push_back(e);
  endtask

  // Last bit driven in the cycle ending at posedge c+1: wren seen in cycle c+1, done in c+2
  task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    push(K_WREN, a, d, c + 1);
    push(K_DONE, '0, '0, c + 2);
  endtask

  // READ in cycle c+1, reply bits in c+2..c+9, done in c+10
  task automatic exp_read(input logic [DW-1:0] d, input int c, input int nb);
    for (int i = 0; i < nb; i++) push(K_BIT, '0, DW'(d[DW-1-i]), c + 2 + i);
    if (nb == DW) push(K_DONE, '0, '0, c + 2 + DW);
  endtask

  task automatic take(input int k, input logic [AW-1:0] a, input logic [DW-1:0] v, input string nm);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d addr %0h val %0h, expected none", nm, cyc, a, v);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.addr !== a || e.val !== v) begin
        errors++;
        $display("FAIL %s: got kind %0d cyc %0d addr %0h val %0h, expected kind %0d cyc %0d addr %0h val %0h",
                 nm, k, cyc, a, v, e.kind, e.cyc, e.addr, e.val);
      end
    end
  endtask

  // Monitor
  initial forever begin
    @(negedge clock);
    if (rstn) begin
      if (ram_wren)          take(K_WREN, ram_address, ram_data_in, "wren");
      if (bif.bus_out_valid) take(K_BIT, '0, DW'(bif.bus_out), "bus_out");
      if (bif.done)          take(K_DONE, '0, '0, "done");
      if (bif.err)           take(K_ERR, '0, '0, "err");
    end
  end

  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int nbits, input int gap, output int last_c);
    logic [AW+DW:0] fr;
    fr = {rw, a, d};
    last_c = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (gap) begin
        @(negedge clock); bif.bus_in_valid = 1'b0; bif.bus_in = 1'b0;
      end
      @(negedge clock);
      bif.bus_in       = fr[AW+DW-i];
      bif.bus_in_valid = 1'b1;
      last_c           = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock); bif.bus_in_valid = 1'b0; bif.bus_in = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bif.bus_in = 1'b0; bif.bus_in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_err", bif.err, 0);
    chk("rst_bus_out", bif.bus_out, 0);
    chk("rst_bus_out_valid", bif.bus_out_valid, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_wdata", ram_data_in, 0);
    repeat (3) @(negedge clock);
    rstn = 1'b1;
    idle(2);

    // Write 0x005 <= 0xA7, continuous bits
    send(1'b1, 12'h005, 8'hA7, 1 + AW + DW, 0, c);
    exp_write(12'h005, 8'hA7, c);
    idle(2);
    chk("busy_during_done", bif.busy, 1);
    idle(1);
    chk("busy_after_write", bif.busy, 0);

    // Read back 0x005 -> 1,0,1,0,0,1,1,1
    send(1'b0, 12'h005, 8'h00, 1 + AW, 0, c);
    exp_read(8'hA7, c, DW);
    idle(12);
    chk("busy_after_read", bif.busy, 0);

    // Gapped write 0xFFF <= 0x3C, 3 idle cycles between bits
    send(1'b1, 12'hFFF, 8'h3C, 1 + AW + DW, 3, c);
    exp_write(12'hFFF, 8'h3C, c);
    idle(4);
    chk("busy_after_gapped", bif.busy, 0);

    // Timeout: rw + 5 address bits, then 16 idle cycles
    send(1'b1, 12'hABC, 8'h00, 6, 0, c);
    push(K_ERR, '0, '0, c + 17);
    idle(16);
    idle(2);
    chk("busy_after_abort", bif.busy, 0);

    // Next frame after abort: write 0x123 <= 0x5A
    send(1'b1, 12'h123, 8'h5A, 1 + AW + DW, 0, c);
    exp_write(12'h123, 8'h5A, c);
    idle(4);

    // Reset during the 4th reply bit of a read of 0x005
    send(1'b0, 12'h005, 8'h00, 1 + AW, 0, c);
    exp_read(8'hA7, c, 3);
    @(posedge clock);
    #1 bif.bus_in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_bus_out_valid", bif.bus_out_valid, 0);
    chk("mid_rst_bus_out", bif.bus_out, 0);
    chk("mid_rst_busy", bif.busy, 0);
    chk("mid_rst_addr", ram_address, 0);
    chk("mid_rst_done", bif.done, 0);
    idle(2);
    rstn = 1'b1;
    idle(2);
    chk("busy_after_rst", bif.busy, 0);

    // Fresh frame after reset: read 0xFFF -> 0x3C
    send(1'b0, 12'hFFF, 8'h00, 1 + AW, 0, c);
    exp_read(8'h3C, c, DW);
    idle(12);

    // Back-to-back: read 0x123, junk bits while busy, write rw in the first IDLE cycle
    send(1'b0, 12'h123, 8'h00, 1 + AW, 0, c);
    exp_read(8'h5A, c, DW);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      bif.bus_in       = ~i[0];
      bif.bus_in_valid = 1'b1;
    end
    send(1'b1, 12'h800, 8'h01, 1 + AW + DW, 0, c);
    exp_write(12'h800, 8'h01, c);
    idle(4);
    send(1'b0, 12'h800, 8'h00, 1 + AW, 0, c);
    exp_read(8'h01, c, DW);
    idle(12);

    idle(5);
    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
